vga_sync_monitor: RTL and testbench



---
 rtl/vga_sync_monitor.sv | 186 ++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: measures line/frame geometry from hs/vs,
// locks after a run of clean frames and regenerates pixel coordinates.
module vga_sync_monitor #(
  parameter int HD          = 640,
  parameter int HTOTAL      = 800,
  parameter int HS_START    = 656,
  parameter int HS_WIDTH    = 96,
  parameter int VD          = 480,
  parameter int VTOTAL      = 525,
  parameter int VS_START    = 513,
  parameter int VS_WIDTH    = 2,
  parameter int LOCK_FRAMES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic        locked,
  output logic [9:0]  rx_x,
  output logic [9:0]  rx_y,
  output logic        rx_visible,
  output logic        frame_start,
  output logic [10:0] meas_htotal,
  output logic [10:0] meas_vtotal,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [10:0] CNT_MAX    = 11'h7ff;
  localparam logic [10:0] HTOTAL_L   = 11'(HTOTAL);
  localparam logic [10:0] TIMEOUT_L  = 11'(2 * HTOTAL);
  localparam logic [10:0] HS_WIDTH_L = 11'(HS_WIDTH);
  localparam logic [10:0] VTOTAL_L   = 11'(VTOTAL);
  localparam logic [10:0] VS_WIDTH_L = 11'(VS_WIDTH);
  localparam logic [9:0]  X_LAST     = 10'(HTOTAL - 1);
  localparam logic [9:0]  Y_LAST     = 10'(VTOTAL - 1);
  localparam logic [9:0]  HS_START_L = 10'(HS_START);
  localparam logic [9:0]  VS_START_L = 10'(VS_START);
  localparam logic [9:0]  HD_L       = 10'(HD);
  localparam logic [9:0]  VD_L       = 10'(VD);
  localparam logic [7:0]  LOCK_L     = 8'(LOCK_FRAMES);

  state_t      state_reg;
  logic [7:0]  good_reg;
  logic        hs_prev_reg, vs_prev_reg;
  logic [10:0] tc_reg, hw_reg, lc_reg, vw_reg;
  logic        h_seen_reg, v_seen_reg, to_armed_reg, frame_bad_reg;
  logic [9:0]  x_reg, y_reg;
  logic        visible_reg, frame_start_reg;
  logic [10:0] meas_h_reg, meas_v_reg;
  logic [7:0]  err_reg;

  logic        hs_rise, hs_fall, vs_rise, vs_fall;
  logic [10:0] tc_next, hw_next, lc_next, vw_next;
  logic        h_err, v_err, any_err, bad_now;
  logic [9:0]  x_next, y_next;
  logic [7:0]  good_inc;
  logic        lock_reached, lock_next;

  assign hs_rise = hs_in & ~hs_prev_reg;
  assign hs_fall = ~hs_in & hs_prev_reg;
  assign vs_rise = vs_in & ~vs_prev_reg;
  assign vs_fall = ~vs_in & vs_prev_reg;

  always_comb begin
    tc_next = tc_reg;
    hw_next = hw_reg;
    lc_next = lc_reg;
    vw_next = vw_reg;
    if (hs_rise) tc_next = 11'd1;
    else if (tc_reg != CNT_MAX) tc_next = tc_reg + 11'd1;
    if (hs_rise) hw_next = 11'd1;
    else if (hs_in && hw_reg != CNT_MAX) hw_next = hw_reg + 11'd1;
    if (vs_rise) lc_next = 11'd1;
    else if (hs_rise && lc_reg != CNT_MAX) lc_next = lc_reg + 11'd1;
    // vs width is counted in lines, i.e. hs rising edges seen while vs is high
    if (vs_rise) vw_next = {10'd0, hs_rise};
    else if (vs_in && hs_rise && vw_reg != CNT_MAX) vw_next = vw_reg + 11'd1;
  end

  // Width/length checks only apply once a genuine rising edge has been seen
  assign h_err = (hs_rise & h_seen_reg & (tc_reg != HTOTAL_L))
               | (hs_fall & h_seen_reg & (hw_reg != HS_WIDTH_L))
               | (to_armed_reg & ~hs_rise & (tc_next == TIMEOUT_L));
  assign v_err = (vs_rise & v_seen_reg & (lc_reg != VTOTAL_L))
               | (vs_fall & v_seen_reg & (vw_reg != VS_WIDTH_L));
  assign any_err = h_err | v_err;
  assign bad_now = frame_bad_reg | any_err;

  always_comb begin
    x_next = (x_reg == X_LAST) ? 10'd0 : x_reg + 10'd1;
    y_next = y_reg;
    if (hs_rise) x_next = HS_START_L;
    else if (x_reg == X_LAST) y_next = (y_reg == Y_LAST) ? 10'd0 : y_reg + 10'd1;
    if (vs_rise) y_next = VS_START_L;
  end

  assign good_inc     = good_reg + 8'd1;
  assign lock_reached = good_inc >= LOCK_L;
  assign lock_next    = ((state_reg == LOCKED) & ~any_err)
                      | ((state_reg == CHECK) & vs_rise & ~bad_now & lock_reached);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= SEARCH;
      good_reg        <= 8'd0;
      hs_prev_reg     <= 1'b1;
      vs_prev_reg     <= 1'b1;
      tc_reg          <= 11'd0;
      hw_reg          <= 11'd0;
      lc_reg          <= 11'd0;
      vw_reg          <= 11'd0;
      h_seen_reg      <= 1'b0;
      v_seen_reg      <= 1'b0;
      to_armed_reg    <= 1'b0;
      frame_bad_reg   <= 1'b0;
      x_reg           <= 10'd0;
      y_reg           <= 10'd0;
      visible_reg     <= 1'b0;
      frame_start_reg <= 1'b0;
      meas_h_reg      <= 11'd0;
      meas_v_reg      <= 11'd0;
      err_reg         <= 8'd0;
    end else begin
      frame_start_reg <= p_tick & lock_next & (x_next == 10'd0) & (y_next == 10'd0);
      if (p_tick) begin
        hs_prev_reg <= hs_in;
        vs_prev_reg <= vs_in;
        tc_reg      <= tc_next;
        hw_reg      <= hw_next;
        lc_reg      <= lc_next;
        vw_reg      <= vw_next;
        x_reg       <= x_next;
        y_reg       <= y_next;
        visible_reg <= lock_next & (x_next < HD_L) & (y_next < VD_L);
        if (hs_rise) begin
          h_seen_reg   <= 1'b1;
          to_armed_reg <= 1'b1;
          if (h_seen_reg) meas_h_reg <= tc_reg;
        end else if (tc_next == TIMEOUT_L) begin
          to_armed_reg <= 1'b0;
        end
        if (vs_rise) begin
          v_seen_reg <= 1'b1;
          if (v_seen_reg) meas_v_reg <= lc_reg;
        end
        frame_bad_reg <= vs_rise ? 1'b0 : bad_now;
        if (any_err && err_reg != 8'hff) err_reg <= err_reg + 8'd1;
        case (state_reg)
          SEARCH: begin
            if (vs_rise) begin
              state_reg <= CHECK;
              good_reg  <= 8'd0;
            end
          end
          CHECK: begin
            if (vs_rise) begin
              if (bad_now) begin
                good_reg <= 8'd0;
              end else begin
                good_reg <= good_inc;
                if (lock_reached) state_reg <= LOCKED;
              end
            end
          end
          LOCKED: begin
            if (any_err) state_reg <= SEARCH;
          end
          default: state_reg <= SEARCH;
        endcase
      end
    end
  end

  assign locked      = (state_reg == LOCKED);
  assign rx_x        = x_reg;
  assign rx_y        = y_reg;
  assign rx_visible  = visible_reg;
  assign frame_start = frame_start_reg;
  assign meas_htotal = meas_h_reg;
  assign meas_vtotal = meas_v_reg;
  assign err_count   = err_reg;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor: a scaled-down timing generator keeps each lock
// sequence short; vsync edges are aligned with the hsync leading edge.
module tb_vga_sync_monitor;

  localparam int HD = 16, HT = 24, HSS = 18, HSW = 3;
  localparam int VD = 8, VT = 14, VSS = 10, VSW = 2, LF = 3;
  localparam int F_NONE = 0, F_LONG = 1, F_RESET = 2, F_VSWIDE = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p_tick = 1'b0;
  logic        hs_in = 1'b0;
  logic        vs_in = 1'b0;
  logic        locked;
  logic [9:0]  rx_x, rx_y;
  logic        rx_visible, frame_start;
  logic [10:0] meas_htotal, meas_vtotal;
  logic [7:0]  err_count;

  vga_sync_monitor #(
    .HD(HD), .HTOTAL(HT), .HS_START(HSS), .HS_WIDTH(HSW),
    .VD(VD), .VTOTAL(VT), .VS_START(VSS), .VS_WIDTH(VSW), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hs_in(hs_in), .vs_in(vs_in),
    .locked(locked), .rx_x(rx_x), .rx_y(rx_y), .rx_visible(rx_visible),
    .frame_start(frame_start), .meas_htotal(meas_htotal), .meas_vtotal(meas_vtotal),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int fault;
    int n_vs;
    int extra;
    int exp_locked;
    int exp_err;
    int exp_mh;
    int exp_mv;
  } step_t;

  step_t steps[14];
  int checks = 0;
  int errors = 0;
  int gx = 0, gy = 0, last_x = 0, last_y = 0;
  int vs_w = VSW;
  int vs_emitted = 0;
  int fs_cnt = 0;
  logic gen_vs_prev = 1'b0;
  logic stuck_low = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic raw_tick(input logic h, input logic v);
    p_tick = 1'b1;
    hs_in = h;
    vs_in = v;
    @(negedge clk);
    p_tick = 1'b0;
    fs_cnt += int'(frame_start);
    @(negedge clk);
    fs_cnt += int'(frame_start);
  endtask

  function automatic logic gen_hs(input int x);
    return (x >= HSS) && (x < HSS + HSW);
  endfunction

  function automatic logic gen_vs(input int x, input int y, input int w);
    int p, s;
    p = y * HT + x;
    s = VSS * HT + HSS;
    return (p >= s) && (p < s + w * HT);
  endfunction

  task automatic emit(input int x, input int y);
    logic h, v;
    h = gen_hs(x) & ~stuck_low;
    v = gen_vs(x, y, vs_w);
    if (v && !gen_vs_prev) vs_emitted++;
    gen_vs_prev = v;
    raw_tick(h, v);
    last_x = x;
    last_y = y;
  endtask

  task automatic gen_step();
    emit(gx, gy);
    if (gx == HT - 1) begin
      gx = 0;
      gy = (gy == VT - 1) ? 0 : gy + 1;
    end else begin
      gx++;
    end
  endtask

  task automatic do_reset();
    p_tick = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    gx = 0;
    gy = 0;
    gen_vs_prev = 1'b0;
    stuck_low = 1'b0;
    vs_w = VSW;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " locked"}, int'(locked), 0);
    check({tag, " rx_x"}, int'(rx_x), 0);
    check({tag, " rx_y"}, int'(rx_y), 0);
    check({tag, " rx_visible"}, int'(rx_visible), 0);
    check({tag, " frame_start"}, int'(frame_start), 0);
    check({tag, " meas_htotal"}, int'(meas_htotal), 0);
    check({tag, " meas_vtotal"}, int'(meas_vtotal), 0);
    check({tag, " err_count"}, int'(err_count), 0);
  endtask

  initial begin
    int target, vis_cnt, err_base;

    // {fault, vs rises to pass, extra ticks, locked, err_count, meas_h, meas_v}
    steps[0]  = '{F_NONE,   0, 200, 0, 0, 24,  0};
    steps[1]  = '{F_NONE,   1,   0, 0, 0, 24,  0};
    steps[2]  = '{F_NONE,   2,   0, 0, 0, 24, 14};
    steps[3]  = '{F_NONE,   1,   0, 1, 0, 24, 14};
    steps[4]  = '{F_NONE,   0, 100, 1, 0, 24, 14};
    steps[5]  = '{F_LONG,   0,  40, 0, 1, 25, 14};
    steps[6]  = '{F_NONE,   1,   0, 0, 1, 24, 14};
    steps[7]  = '{F_NONE,   2,   0, 0, 1, 24, 14};
    steps[8]  = '{F_NONE,   1,   0, 1, 1, 24, 14};
    steps[9]  = '{F_RESET,  0,  30, 0, 0,  0,  0};
    steps[10] = '{F_NONE,   3,   0, 0, 0, 24, 14};
    steps[11] = '{F_VSWIDE, 1,   0, 0, 1, 24, 14};
    steps[12] = '{F_NONE,   2,   0, 0, 1, 24, 14};
    steps[13] = '{F_NONE,   1,   0, 1, 1, 24, 14};

    @(negedge clk);
    do_reset();
    check_reset_state("reset");

    for (int i = 0; i < 14; i++) begin
      vs_w = VSW;
      case (steps[i].fault)
        F_LONG:   emit(last_x, last_y);
        F_RESET:  begin hs_in = 1'b0; vs_in = 1'b0; do_reset(); end
        F_VSWIDE: vs_w = 3;
        default:  ;
      endcase
      target = vs_emitted + steps[i].n_vs;
      for (int g = 0; g < 5000 && vs_emitted < target; g++) gen_step();
      repeat (steps[i].extra) gen_step();
      check($sformatf("step%0d locked", i), int'(locked), steps[i].exp_locked);
      check($sformatf("step%0d err_count", i), int'(err_count), steps[i].exp_err);
      check($sformatf("step%0d meas_htotal", i), int'(meas_htotal), steps[i].exp_mh);
      check($sformatf("step%0d meas_vtotal", i), int'(meas_vtotal), steps[i].exp_mv);
      $display("step %0d: locked=%0d err_count=%0d meas_htotal=%0d meas_vtotal=%0d",
               i, locked, err_count, meas_htotal, meas_vtotal);
    end

    // One full locked frame: coordinates, visible area and frame_start
    for (int g = 0; g < 2 * HT * VT && !(gx == 0 && gy == 0); g++) gen_step();
    fs_cnt = 0;
    vis_cnt = 0;
    for (int t = 0; t < HT * VT; t++) begin
      gen_step();
      check($sformatf("rx_x at (%0d,%0d)", last_x, last_y), int'(rx_x), last_x);
      check($sformatf("rx_y at (%0d,%0d)", last_x, last_y), int'(rx_y), last_y);
      check($sformatf("rx_visible at (%0d,%0d)", last_x, last_y), int'(rx_visible),
            int'(last_x < HD && last_y < VD));
      vis_cnt += int'(rx_visible);
    end
    check("frame_start clocks per frame", fs_cnt, 1);
    check("visible ticks per frame", vis_cnt, HD * VD);
    check("locked after frame", int'(locked), 1);
    $display("frame: frame_start clocks=%0d visible ticks=%0d", fs_cnt, vis_cnt);

    // hs stuck low after lock: one timeout error only
    err_base = int'(err_count);
    repeat (HSS + HSW + HT) gen_step();
    stuck_low = 1'b1;
    repeat (40) gen_step();
    check("stuck: no error before timeout", int'(err_count), err_base);
    check("stuck: locked before timeout", int'(locked), 1);
    repeat (10) gen_step();
    check("stuck: timeout error", int'(err_count), err_base + 1);
    check("stuck: lock lost", int'(locked), 0);
    repeat (60) gen_step();
    check("stuck: single timeout", int'(err_count), err_base + 1);
    $display("stuck: err_count=%0d locked=%0d", err_count, locked);

    // hs already high at reset release must not count as an edge
    hs_in = 1'b1;
    vs_in = 1'b0;
    do_reset();
    check_reset_state("reset hs high");
    repeat (5) raw_tick(1'b1, 1'b0);
    check("hs high: meas_htotal", int'(meas_htotal), 0);
    repeat (10) raw_tick(1'b0, 1'b0);
    check("hs high: no width error", int'(err_count), 0);
    repeat (3) raw_tick(1'b1, 1'b0);
    repeat (27) raw_tick(1'b0, 1'b0);
    check("hs high: meas after 1st rise", int'(meas_htotal), 0);
    check("hs high: err after 1st rise", int'(err_count), 0);
    raw_tick(1'b1, 1'b0);
    check("hs high: meas after 2nd rise", int'(meas_htotal), 30);
    check("hs high: length error", int'(err_count), 1);
    check("hs high: not locked", int'(locked), 0);
    $display("hs high at reset: meas_htotal=%0d err_count=%0d", meas_htotal, err_count);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
